uart_rx_byte: RTL and testbench

- 8N1 UART receiver: oversamples the asynchronous serial line with the system clock and recovers one byte per frame.
- Sits directly upstream of the byte loopback/consumer stage.
- Delivers each received byte on o_rx_byte together with a one-cycle o_rx_byte_rdy strobe; the consumer may capture on that strobe.
- Also reports framing errors and a busy status.

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx_byte.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_byte.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame geometry and default bit timing.
package uart_pkg;

  // Data bits per 8N1 frame.
  localparam int DATA_BITS = 8;

  // 100 MHz system clock / 115200 baud. The receiver and the future transmitter both use it.
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for bringing an asynchronous level into i_clk.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops; the first may go metastable, the second gives it a cycle to settle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver. Oversamples the serial line with i_clk, samples each bit near its
// centre and delivers one byte per frame with a one-cycle ready strobe.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic       o_rx_byte_rdy,
  output logic [7:0] o_rx_byte,
  output logic       o_frame_err,
  output logic       o_busy
);

  // The counter only ever holds 0..N-1, so clog2(N) bits are enough.
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;

  // The counter restarts at 0 on the cycle after a sample point (or the start edge), so a
  // sample point is reached when it reads one less than the interval length.
  localparam logic [CNT_W-1:0] CNT_LAST_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST      = 3'(DATA_BITS - 1);

  logic                 w_rx_s;

  rx_state_t            r_state;
  rx_state_t            w_state_nxt;

  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [2:0]           r_bit_idx;
  logic [2:0]           w_bit_idx_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [7:0]           r_rx_byte;
  logic [7:0]           w_rx_byte_nxt;
  logic                 r_rdy;
  logic                 w_rdy_nxt;
  logic                 r_frame_err;
  logic                 w_frame_err_nxt;

  logic                 w_half_tick;
  logic                 w_full_tick;

  // Line idles high, so the synchronizer resets to 1 to avoid a phantom start bit.
  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync_rx (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_rx),
    .o_q    (w_rx_s)
  );

  assign w_half_tick = (r_cnt == CNT_LAST_HALF);
  assign w_full_tick = (r_cnt == CNT_LAST_FULL);

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath decisions: sample at mid-start, then every full bit period after.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_bit_idx_nxt   = r_bit_idx;
    w_shift_nxt     = r_shift;
    w_rx_byte_nxt   = r_rx_byte;
    w_rdy_nxt       = 1'b0;
    w_frame_err_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        // Counter is held at 0 here so timing starts exactly at the detected edge.
        w_cnt_nxt = '0;
        if (!w_rx_s) begin
          w_state_nxt = START;
        end
      end

      START: begin
        if (w_half_tick) begin
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = '0;
          // Still low at mid-start means a real start bit; otherwise it was a glitch.
          w_state_nxt   = w_rx_s ? IDLE : DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      DATA: begin
        if (w_full_tick) begin
          w_cnt_nxt   = '0;
          // LSB arrives first, so shift in from the top.
          w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
          if (r_bit_idx == BIT_LAST) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      STOP: begin
        if (w_full_tick) begin
          w_cnt_nxt = '0;
          if (w_rx_s) begin
            w_rx_byte_nxt = r_shift;
            w_rdy_nxt     = 1'b1;
            w_state_nxt   = IDLE;
          end else begin
            // Bad stop bit: keep the last good byte and wait out the low line.
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = BREAK;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      BREAK: begin
        w_cnt_nxt = '0;
        if (w_rx_s) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Counters, shift register, held output byte and registered strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_rx_byte   <= '0;
      r_rdy       <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_rx_byte   <= w_rx_byte_nxt;
      r_rdy       <= w_rdy_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  assign o_rx_byte_rdy = r_rdy;
  assign o_rx_byte     = r_rx_byte;
  assign o_frame_err   = r_frame_err;
  assign o_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Testbench for uart_rx_byte with N=16: directed frames, scoreboard of expected strobes.
module tb_uart_rx_byte;

  localparam int N = 16;
  localparam int H = N / 2;
  // Drive cycle of the start edge -> cycle in which a strobe is visible.
  localparam int LAT = 2 + H + 9 * N + 1;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       rdy;
  logic [7:0] rx_byte;
  logic       ferr;
  logic       busy;

  int   cyc;
  int   n_total;
  int   n_pass;
  int   n_fail;
  int   err_cnt;
  bit   busy_seen;
  logic [7:0] last_byte;

  exp_t rdy_q[$];
  int   err_q[$];
  int   rdy_cyc[$];

  uart_rx_byte #(
    .CLKS_PER_BIT(N)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rx         (rx),
    .o_rx_byte_rdy(rdy),
    .o_rx_byte    (rx_byte),
    .o_frame_err  (ferr),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: pop the scoreboard whenever the DUT strobes.
  always @(negedge clk) begin
    if (busy) busy_seen = 1'b1;
    if (rdy || ferr) begin
      check("strobe_exclusive", 32'(rdy & ferr), 32'd0);
    end
    if (rdy) begin
      rdy_cyc.push_back(cyc);
      check("rdy_expected", 32'(rdy_q.size() != 0), 32'd1);
      if (rdy_q.size() != 0) begin
        exp_t e;
        e = rdy_q.pop_front();
        check("rdy_byte", 32'(rx_byte), 32'(e.data));
        check("rdy_cycle", cyc, e.cyc);
        last_byte = e.data;
      end
    end
    if (ferr) begin
      err_cnt++;
      check("ferr_expected", 32'(err_q.size() != 0), 32'd1);
      if (err_q.size() != 0) begin
        int ec;
        ec = err_q.pop_front();
        check("ferr_cycle", cyc, ec);
      end
      check("ferr_byte_held", 32'(rx_byte), 32'(last_byte));
    end
  end

  // One frame with sender bit period per; pushes the expected strobe when the start bit goes out.
  task automatic send_frame(input logic [7:0] b, input int per, input logic stop_bit, input int gap);
    @(negedge clk);
    rx = 1'b0;
    if (stop_bit) rdy_q.push_back('{data: b, cyc: cyc + LAT});
    else          err_q.push_back(cyc + LAT);
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (per) @(negedge clk);
    end
    rx = stop_bit;
    repeat (per - 1) @(negedge clk);
    if (stop_bit) begin
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && (rdy_q.size() != 0 || err_q.size() != 0); i++) begin
      @(negedge clk);
    end
    check(tag, 32'(rdy_q.size() + err_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_total   = 0;
    n_pass    = 0;
    n_fail    = 0;
    err_cnt   = 0;
    busy_seen = 1'b0;
    last_byte = 8'h00;
    rst_n     = 1'b0;
    rx        = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_rdy", 32'(rdy), 32'd0);
    check("reset_byte", 32'(rx_byte), 32'h00);
    check("reset_ferr", 32'(ferr), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame, exact strobe timing
    send_frame(8'hA5, N, 1'b1, 2 * N);
    wait_drain("drain_a5", 400);
    check("a5_rdy_low_after", 32'(rdy), 32'd0);

    // Back-to-back frames with a single stop bit
    send_frame(8'h00, N, 1'b1, 0);
    send_frame(8'hFF, N, 1'b1, 2 * N);
    wait_drain("drain_b2b", 400);
    check("b2b_spacing", rdy_cyc[rdy_cyc.size()-1] - rdy_cyc[rdy_cyc.size()-2], 32'(10 * N));

    // Short low glitch: busy pulses, no strobe
    busy_seen = 1'b0;
    @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (2 * N) @(negedge clk);
    check("glitch_busy_seen", 32'(busy_seen), 32'd1);
    check("glitch_busy_low", 32'(busy), 32'd0);
    send_frame(8'h3C, N, 1'b1, 2 * N);
    wait_drain("drain_3c", 400);

    // Bad stop bit, line held low for 40 bit times
    send_frame(8'h55, N, 1'b0, 0);
    repeat (40 * N) @(negedge clk);
    rx = 1'b1;
    repeat (2 * N) @(negedge clk);
    wait_drain("drain_55", 100);
    check("break_single_ferr", err_cnt, 32'd1);
    check("break_byte_held", 32'(rx_byte), 32'h3C);
    send_frame(8'h81, N, 1'b1, 2 * N);
    wait_drain("drain_81", 400);

    // Reset during data bit 4
    @(negedge clk);
    rx = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (N) @(negedge clk);
    end
    rx = 1'b1;
    repeat (H) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_rdy", 32'(rdy), 32'd0);
    check("async_rst_byte", 32'(rx_byte), 32'h00);
    check("async_rst_ferr", 32'(ferr), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    last_byte = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * N) @(negedge clk);
    send_frame(8'h7E, N, 1'b1, 2 * N);
    wait_drain("drain_7e", 400);

    // Sender clock off by one cycle per bit in each direction
    send_frame(8'hC3, N - 1, 1'b1, 2 * N);
    wait_drain("drain_c3_fast", 400);
    send_frame(8'hC3, N + 1, 1'b1, 2 * N);
    wait_drain("drain_c3_slow", 400);
    check("final_ferr_count", err_cnt, 32'd1);
    check("final_rdy_count", 32'(rdy_cyc.size()), 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
